// File: rtl/ym3438_accumulator.sv
// ym3438_accumulator
//   Output accumulator stage behind the operator unit. Sums per-slot operator
//   outputs selected by the algorithm into six per-channel accumulators,
//   applies channel-5 DAC substitution, and emits one 9-bit signed sample per
//   channel, time-multiplexed on MOL/MOR with per-channel panning.
//
//   Build option: define YM3438_ACC_CLAMP_EN to saturate the accumulator to
//   [-8192, 8191] before taking bits [13:5]; otherwise the sum wraps.
//
// Ports:
//   MCLK      in   master clock, all state on rising edge
//   IC        in   asynchronous active-high reset
//   c1        in   slot strobe; accumulation advances on edges with c1=1
//   c2        in   output strobe; output registers load on edges with c2=1
//   slot_sync in   current slot is 23; next c1 strobe starts slot 0
//   op_out    in   [13:0] signed operator output of the current slot
//   alg_out   in   current slot's operator contributes to the channel output
//   pan_l/r   in   panning bits of the current slot's channel
//   dac_en    in   replace channel 5 result with the DAC sample
//   dac_data  in   [8:0] offset-binary DAC sample
//   MOL/MOR   out  [8:0] signed channel sample, left/right
//   ch_o      out  [2:0] channel of the sample on MOL/MOR
//   out_valid out  MOL/MOR hold a fresh sample
module ym3438_accumulator (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       c1,
  input  logic       c2,
  input  logic       slot_sync,
  input  logic [13:0] op_out,
  input  logic       alg_out,
  input  logic       pan_l,
  input  logic       pan_r,
  input  logic       dac_en,
  input  logic [8:0] dac_data,
  output logic [8:0] MOL,
  output logic [8:0] MOR,
  output logic [2:0] ch_o,
  output logic       out_valid
);

  localparam int unsigned SLOT_W    = 5;
  localparam int unsigned GRP_W     = 2;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned NUM_SLOTS = 24;
  localparam int unsigned NUM_CH    = 6;
  localparam int unsigned OP_W      = 14;
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned RES_W     = 9;
  localparam int unsigned DAC_CH    = 5;
  localparam int unsigned LAST_GRP  = 3;

  logic [SLOT_W-1:0]       slot;
  logic [GRP_W-1:0]        grp;
  logic [CH_W-1:0]         ch;
  logic                    slot_last;
  logic                    finalize;

  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] acc_sum;
  logic [RES_W-1:0]        res9;

  logic [RES_W-1:0]        stage_res;
  logic [CH_W-1:0]         stage_ch;
  logic                    stage_pl;
  logic                    stage_pr;
  logic                    stage_full;

  // Slot decode: group = slot / 6, channel = slot mod 6
  always_comb begin
    grp = GRP_W'(0);
    if (slot >= SLOT_W'(18))      grp = GRP_W'(3);
    else if (slot >= SLOT_W'(12)) grp = GRP_W'(2);
    else if (slot >= SLOT_W'(6))  grp = GRP_W'(1);
    ch        = CH_W'(slot - SLOT_W'(grp) * SLOT_W'(6));
    slot_last = (slot == SLOT_W'(NUM_SLOTS - 1));
    finalize  = c1 && (grp == GRP_W'(LAST_GRP));
  end

  // Current channel accumulator and its next value (group 0 loads, others add)
  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) acc_cur = acc[i];
    end
    addend  = alg_out ? {{(ACC_W-OP_W){op_out[OP_W-1]}}, op_out} : '0;
    acc_sum = (grp == GRP_W'(0)) ? addend : acc_cur + addend;
  end

  // Channel result: optional saturation, take [13:5], DAC override on ch 5
  always_comb begin
`ifdef YM3438_ACC_CLAMP_EN
    if (acc_sum > 16'sd8191)       res9 = 9'h0FF;
    else if (acc_sum < -16'sd8192) res9 = 9'h100;
    else                           res9 = acc_sum[13:5];
`else
    res9 = acc_sum[13:5];
`endif
    if (dac_en && (ch == CH_W'(DAC_CH))) res9 = {~dac_data[8], dac_data[7:0]};
  end

  // Slot counter, resynchronised by slot_sync
  always_ff @(posedge MCLK or posedge IC) begin
    if (IC) begin
      slot <= '0;
    end else if (c1) begin
      slot <= (slot_sync || slot_last) ? '0 : slot + SLOT_W'(1);
    end
  end

  // Per-channel accumulators
  always_ff @(posedge MCLK or posedge IC) begin
    if (IC) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (c1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch == CH_W'(i)) acc[i] <= acc_sum;
      end
    end
  end

  // Stage register between finalize (c1) and output (c2); finalize wins a tie
  always_ff @(posedge MCLK or posedge IC) begin
    if (IC) begin
      stage_res  <= '0;
      stage_ch   <= '0;
      stage_pl   <= 1'b0;
      stage_pr   <= 1'b0;
      stage_full <= 1'b0;
    end else begin
      if (finalize) begin
        stage_res  <= res9;
        stage_ch   <= ch;
        stage_pl   <= pan_l;
        stage_pr   <= pan_r;
        stage_full <= 1'b1;
      end else if (c2) begin
        stage_full <= 1'b0;
      end
    end
  end

  // Output registers; c2 sees the stage contents from before this edge
  always_ff @(posedge MCLK or posedge IC) begin
    if (IC) begin
      MOL       <= '0;
      MOR       <= '0;
      ch_o      <= '0;
      out_valid <= 1'b0;
    end else if (c2) begin
      if (stage_full) begin
        MOL       <= stage_pl ? stage_res : '0;
        MOR       <= stage_pr ? stage_res : '0;
        ch_o      <= stage_ch;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ym3438_accumulator.sv
// Bench for ym3438_accumulator: directed frames, expected samples queued at
// stimulus time and checked by a monitor on every c2 edge that shows a sample.
module tb_ym3438_accumulator;

  logic        MCLK = 1'b0;
  logic        IC;
  logic        c1;
  logic        c2;
  logic        slot_sync;
  logic [13:0] op_out;
  logic        alg_out;
  logic        pan_l;
  logic        pan_r;
  logic        dac_en;
  logic [8:0]  dac_data;
  logic [8:0]  MOL;
  logic [8:0]  MOR;
  logic [2:0]  ch_o;
  logic        out_valid;

  ym3438_accumulator dut (
    .MCLK(MCLK), .IC(IC), .c1(c1), .c2(c2), .slot_sync(slot_sync),
    .op_out(op_out), .alg_out(alg_out), .pan_l(pan_l), .pan_r(pan_r),
    .dac_en(dac_en), .dac_data(dac_data),
    .MOL(MOL), .MOR(MOR), .ch_o(ch_o), .out_valid(out_valid)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [2:0] ch;
    logic [8:0] l;
    logic [8:0] r;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [13:0] f_op  [24];
  logic        f_alg [24];
  logic        f_pl  [6];
  logic        f_pr  [6];

`ifdef YM3438_ACC_CLAMP_EN
  localparam logic [8:0] CH2_BIG = 9'h0FF;
  localparam logic [8:0] NEG_BIG = 9'h100;
`else
  localparam logic [8:0] CH2_BIG = 9'h1FF;
  localparam logic [8:0] NEG_BIG = 9'h000;
`endif

  // Monitor: pop and compare on every c2 edge that presents a fresh sample
  always @(posedge MCLK) begin
    if (c2 === 1'b1) begin
      #1;
      if (out_valid === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_sample: got ch=%0d MOL=%h MOR=%h, required no sample",
                   ch_o, MOL, MOR);
        end else begin
          mon_e = sb.pop_front();
          if (ch_o !== mon_e.ch || MOL !== mon_e.l || MOR !== mon_e.r) begin
            n_fail++;
            $display("FAIL sample: got ch=%0d MOL=%h MOR=%h, required ch=%0d MOL=%h MOR=%h",
                     ch_o, MOL, MOR, mon_e.ch, mon_e.l, mon_e.r);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic [8:0] l, input logic [8:0] r);
    exp_t e;
    e.ch = 3'(c);
    e.l  = l;
    e.r  = r;
    sb.push_back(e);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 24; i++) begin
      f_op[i]  = '0;
      f_alg[i] = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      f_pl[i] = 1'b1;
      f_pr[i] = 1'b1;
    end
  endtask

  task automatic set_ch(input int c, input logic [13:0] op, input logic pl, input logic pr);
    for (int g = 0; g < 4; g++) begin
      f_op[c + 6*g]  = op;
      f_alg[c + 6*g] = 1'b1;
    end
    f_pl[c] = pl;
    f_pr[c] = pr;
  endtask

  task automatic strobe(input logic s1, input logic s2, input int s, input logic sync);
    @(negedge MCLK);
    c1        = s1;
    c2        = s2;
    slot_sync = sync;
    op_out    = f_op[s];
    alg_out   = f_alg[s];
    pan_l     = f_pl[s % 6];
    pan_r     = f_pr[s % 6];
    @(posedge MCLK);
  endtask

  task automatic run_frame(input logic overlap);
    for (int s = 0; s < 24; s++) begin
      if (overlap) begin
        strobe(1'b1, 1'b1, s, 1'b0);
      end else begin
        strobe(1'b1, 1'b0, s, 1'b0);
        strobe(1'b0, 1'b1, s, 1'b0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge MCLK);
      c1 = 1'b0;
      c2 = 1'b0;
      slot_sync = 1'b0;
    end
  endtask

  initial begin
    IC = 1'b1; c1 = 1'b0; c2 = 1'b0; slot_sync = 1'b0;
    op_out = '0; alg_out = 1'b0; pan_l = 1'b0; pan_r = 1'b0;
    dac_en = 1'b0; dac_data = '0;
    clear_frame();
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check("reset_MOL", 32'(MOL), 32'h0);
    check("reset_MOR", 32'(MOR), 32'h0);
    check("reset_ch_o", 32'(ch_o), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    IC = 1'b0;

    // Frame 1: sums, clamp/wrap, load-not-add at group 0, panning, DAC max
    clear_frame();
    set_ch(0, 14'd1000, 1'b1, 1'b0);
    set_ch(2, 14'd8191, 1'b1, 1'b1);
    set_ch(3, 14'(-320), 1'b1, 1'b1);
    f_op[3] = 14'd5000; f_alg[3] = 1'b0;
    f_op[4] = 14'd100;  f_alg[4] = 1'b1;
    f_op[10] = 14'd100; f_alg[10] = 1'b1;
    f_pl[4] = 1'b0; f_pr[4] = 1'b1;
    dac_en = 1'b1; dac_data = 9'h1FF;
    push(0, 9'd125, 9'd0);
    push(1, 9'd0, 9'd0);
    push(2, CH2_BIG, CH2_BIG);
    push(3, 9'h1E2, 9'h1E2);
    push(4, 9'd0, 9'd6);
    push(5, 9'h0FF, 9'h0FF);
    run_frame(1'b0);

    // Frame 2: negative sums, most-negative boundary, DAC min
    clear_frame();
    set_ch(0, 14'(-1000), 1'b1, 1'b1);
    set_ch(1, 14'(-8192), 1'b1, 1'b1);
    dac_data = 9'h000;
    push(0, 9'h183, 9'h183);
    push(1, NEG_BIG, NEG_BIG);
    push(2, 9'd0, 9'd0);
    push(3, 9'd0, 9'd0);
    push(4, 9'd0, 9'd0);
    push(5, 9'h100, 9'h100);
    run_frame(1'b0);

    // Frame 3: c1 and c2 on the same edge; ch5 drains on a trailing c2
    clear_frame();
    dac_en = 1'b0;
    set_ch(1, 14'd32, 1'b1, 1'b0);
    set_ch(5, 14'd320, 1'b0, 1'b1);
    push(0, 9'd0, 9'd0);
    push(1, 9'd4, 9'd0);
    push(2, 9'd0, 9'd0);
    push(3, 9'd0, 9'd0);
    push(4, 9'd0, 9'd0);
    push(5, 9'd0, 9'd40);
    run_frame(1'b1);
    strobe(1'b0, 1'b1, 0, 1'b0);
    strobe(1'b0, 1'b1, 0, 1'b0);
    @(negedge MCLK);
    c2 = 1'b0;
    check("c2_only_clears_valid", 32'(out_valid), 32'h0);
    check("c2_only_holds_MOR", 32'(MOR), 32'd40);
    check("c2_only_holds_ch_o", 32'(ch_o), 32'd5);

    // Reset mid-frame after ch1 group-2 add
    clear_frame();
    set_ch(1, 14'd500, 1'b1, 1'b1);
    for (int s = 0; s < 14; s++) begin
      strobe(1'b1, 1'b0, s, 1'b0);
      strobe(1'b0, 1'b1, s, 1'b0);
    end
    @(negedge MCLK);
    c2 = 1'b0;
    IC = 1'b1;
    #1;
    check("midreset_MOL", 32'(MOL), 32'h0);
    check("midreset_MOR", 32'(MOR), 32'h0);
    check("midreset_ch_o", 32'(ch_o), 32'h0);
    check("midreset_out_valid", 32'(out_valid), 32'h0);
    @(negedge MCLK);
    IC = 1'b0;
    clear_frame();
    set_ch(1, 14'd100, 1'b1, 1'b1);
    push(0, 9'd0, 9'd0);
    push(1, 9'd12, 9'd12);
    push(2, 9'd0, 9'd0);
    push(3, 9'd0, 9'd0);
    push(4, 9'd0, 9'd0);
    push(5, 9'd0, 9'd0);
    run_frame(1'b0);

    // slot_sync at slot 10 restarts the frame
    clear_frame();
    set_ch(3, 14'd64, 1'b1, 1'b1);
    for (int s = 0; s < 11; s++) begin
      strobe(1'b1, 1'b0, s, (s == 10));
      strobe(1'b0, 1'b1, s, 1'b0);
    end
    push(0, 9'd0, 9'd0);
    push(1, 9'd0, 9'd0);
    push(2, 9'd0, 9'd0);
    push(3, 9'd8, 9'd8);
    push(4, 9'd0, 9'd0);
    push(5, 9'd0, 9'd0);
    run_frame(1'b0);
    idle(4);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
